// File: rtl/alu_arbiter_if.sv
// Requester and ALU-side bus of alu_arbiter.
// slave = arbiter view, master = environment view (requesters plus the ALU itself).
interface alu_arbiter_if #(
  parameter int W     = 32,
  parameter int N_REQ = 2
);
  // Handshake: a request transfers on the edge where req_valid[i] && req_ready[i].
  // A response transfers on the edge where rsp_valid[i] && rsp_ready[i]. Valid never waits on ready.
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ*3-1:0] req_ctrl;
  logic [N_REQ-1:0]   rsp_valid;
  logic [N_REQ-1:0]   rsp_ready;
  logic [W-1:0]       rsp_result;
  logic               rsp_comp;
  logic               rsp_cero;
  logic [W-1:0]       alu_a;
  logic [W-1:0]       alu_b;
  logic [2:0]         alu_control;
  logic [W-1:0]       alu_result;
  logic               alu_comp;
  logic               alu_cero;
  logic               busy;

  modport slave (
    input  req_valid, req_a, req_b, req_ctrl, rsp_ready, alu_result, alu_comp, alu_cero,
    output req_ready, rsp_valid, rsp_result, rsp_comp, rsp_cero, alu_a, alu_b, alu_control, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_ctrl, rsp_ready, alu_result, alu_comp, alu_cero,
    input  req_ready, rsp_valid, rsp_result, rsp_comp, rsp_cero, alu_a, alu_b, alu_control, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between N_REQ requesters, one transaction in flight.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module alu_arbiter #(
  parameter int W     = 32,
  parameter int N_REQ = 2
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output logic [1:0]    dbg_state_o
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  logic [GW-1:0]    grant_q;
  logic [W-1:0]     alu_a_q;
  logic [W-1:0]     alu_b_q;
  logic [2:0]       alu_ctrl_q;
  logic [W-1:0]     result_q;
  logic             comp_q;
  logic             cero_q;
  logic             busy_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [GW-1:0]    win;
  logic [GW-1:0]    cand;
`ifdef ALU_ARB_RR_EN
  logic [GW-1:0]    ptr_q;
`endif

  // Scan from the highest candidate down so the first one in search order is kept.
  always_comb begin
    win  = '0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef ALU_ARB_RR_EN
      cand = GW'((int'(ptr_q) + k) % N_REQ);
`else
      cand = GW'(k);
`endif
      if (bus.req_valid[cand]) win = cand;
    end
  end

  assign bus.req_ready = (!rst && state_q == IDLE && |bus.req_valid)
                         ? (N_REQ'(1) << win) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      result_q    <= '0;
      comp_q      <= 1'b0;
      cero_q      <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
`ifdef ALU_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.req_valid) begin
            grant_q    <= win;
            alu_a_q    <= bus.req_a[win*W +: W];
            alu_b_q    <= bus.req_b[win*W +: W];
            alu_ctrl_q <= bus.req_ctrl[win*3 +: 3];
            busy_q     <= 1'b1;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          result_q    <= bus.alu_result;
          cero_q      <= bus.alu_cero;
          // The ALU only drives comp for the two compare codes.
          comp_q      <= (alu_ctrl_q == 3'b011 || alu_ctrl_q == 3'b100) ? bus.alu_comp : 1'b0;
          rsp_valid_q <= N_REQ'(1) << grant_q;
          alu_a_q     <= '0;
          alu_b_q     <= '0;
          alu_ctrl_q  <= '0;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready[grant_q]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
`ifdef ALU_ARB_RR_EN
            ptr_q       <= (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_control = alu_ctrl_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = result_q;
  assign bus.rsp_comp    = comp_q;
  assign bus.rsp_cero    = cero_q;
  assign bus.busy        = busy_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, directed scenarios, then randomized transactions
// checked against a transaction-level reference model and an expected-response queue.
module tb_alu_arbiter;
  localparam int W = 32;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;
  int n_cmp = 0;
  int n_err = 0;
  int ptr_m = 0;
  logic [W+1:0] exp_q[$];

  alu_arbiter_if #(.W(W), .N_REQ(N)) bus ();
  alu_arbiter #(.W(W), .N_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ALU environment: comp is junk (1) for codes that do not compare.
  always_comb begin
    bus.alu_comp = 1'b1;
    case (bus.alu_control)
      3'b000:  bus.alu_result = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_result = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_result = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_result = bus.alu_a - bus.alu_b;
      3'b100:  bus.alu_result = bus.alu_a - bus.alu_b;
      3'b101:  bus.alu_result = bus.alu_a | bus.alu_b;
      default: bus.alu_result = '0;
    endcase
    if (bus.alu_control == 3'b011) bus.alu_comp = (bus.alu_a == bus.alu_b);
    else if (bus.alu_control == 3'b100) bus.alu_comp = ($signed(bus.alu_a) > $signed(bus.alu_b));
    bus.alu_cero = (bus.alu_result == '0);
  end

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] ref_rsp(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] c);
    logic [W-1:0] r;
    logic cp;
    r = '0;
    cp = 1'b0;
    if (c == 3'd0) r = a + b;
    else if (c == 3'd1 || c == 3'd3 || c == 3'd4) r = a - b;
    else if (c == 3'd2) r = a & b;
    else if (c == 3'd5) r = a | b;
    if (c == 3'd3) cp = (a == b);
    if (c == 3'd4) cp = ($signed(a) > $signed(b));
    return {r, cp, (r == '0)};
  endfunction

  function automatic int exp_winner(input logic [N-1:0] v);
`ifdef ALU_ARB_RR_EN
    for (int k = 0; k < N; k++) if (v[(ptr_m + k) % N]) return (ptr_m + k) % N;
`else
    for (int k = 0; k < N; k++) if (v[k]) return k;
`endif
    return 0;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] c);
    bus.req_a[idx*W +: W] = a;
    bus.req_b[idx*W +: W] = b;
    bus.req_ctrl[idx*3 +: 3] = c;
  endtask

  // Entered at negedge+1 in IDLE with requests driven; returns at negedge+1 back in IDLE.
  task automatic serve(input int idx, input int hold, input logic [N-1:0] next_valid,
                       output int wait_cyc, output logic [W+1:0] got);
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0] c;
    wait_cyc = 0;
    got = '0;
    while (bus.req_ready == '0 && wait_cyc < 20) begin
      @(negedge clk); #1;
      wait_cyc++;
    end
    check("grant", 64'(bus.req_ready), 64'(1) << idx);
    a = bus.req_a[idx*W +: W];
    b = bus.req_b[idx*W +: W];
    c = bus.req_ctrl[idx*3 +: 3];
    exp_q.push_back(ref_rsp(a, b, c));
    @(negedge clk); #1;
    bus.req_valid = next_valid;
    bus.req_a[idx*W +: W] = $urandom;
    bus.req_b[idx*W +: W] = $urandom;
    #1;
    check("exec_busy", 64'(bus.busy), 64'(1));
    check("exec_req_ready", 64'(bus.req_ready), 64'(0));
    check("exec_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("exec_alu_a", 64'(bus.alu_a), 64'(a));
    check("exec_alu_b", 64'(bus.alu_b), 64'(b));
    check("exec_alu_ctrl", 64'(bus.alu_control), 64'(c));
    @(negedge clk); #1;
    for (int h = 0; h <= hold; h++) begin
      got = {bus.rsp_result, bus.rsp_comp, bus.rsp_cero};
      check("rsp_valid", 64'(bus.rsp_valid), 64'(1) << idx);
      check("rsp_data", 64'(got), 64'(exp_q[0]));
      check("rsp_req_ready", 64'(bus.req_ready), 64'(0));
      bus.rsp_ready = (h == hold) ? N'(1 << idx) : ~N'(1 << idx);
      @(negedge clk); #1;
    end
    void'(exp_q.pop_front());
    bus.rsp_ready = '0;
    #1;
    check("done_busy", 64'(bus.busy), 64'(0));
    check("done_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    ptr_m = (idx + 1) % N;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int w;
    int n1;
    logic [W+1:0] got;
    logic [W-1:0] ra;
    logic [N-1:0] v;

    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_ctrl = '0;
    bus.rsp_ready = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    bus.req_valid = 2'b11;
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_result", 64'({bus.rsp_result, bus.rsp_comp, bus.rsp_cero}), 64'(0));
    check("rst_alu", 64'({bus.alu_a, bus.alu_b, bus.alu_control}), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("idle_no_grant", 64'(bus.req_ready), 64'(0));

    // 1: single request on requester 0
    set_req(0, 32'd3, 32'd4, 3'b000);
    bus.req_valid = 2'b01;
    #1;
    serve(0, 0, 2'b00, w, got);
    check("t1_wait", 64'(w), 64'(0));
    check("t1_rsp", 64'(got), 64'({32'd7, 1'b0, 1'b0}));

    // 2: both held; round-robin alternates, fixed priority starves requester 1
    set_req(0, $urandom, $urandom, 3'($urandom_range(0, 5)));
    set_req(1, $urandom, $urandom, 3'($urandom_range(0, 5)));
    bus.req_valid = 2'b11;
    #1;
    n1 = 0;
    for (int i = 0; i < 4; i++) begin
      w = exp_winner(bus.req_valid);
      if (w == 1) n1++;
      serve(w, 0, (i == 3) ? 2'b00 : 2'b11, w, got);
    end
`ifdef ALU_ARB_RR_EN
    check("t2_rr_share", 64'(n1), 64'(2));
`else
    check("t2_fixed_starve", 64'(n1), 64'(0));
`endif

    // 3: compare codes on requester 1, and comp masked for add
    set_req(1, 32'd5, 32'd3, 3'b100);
    bus.req_valid = 2'b10;
    #1;
    serve(1, 0, 2'b00, w, got);
    check("t3_gt", 64'(got), 64'({32'd2, 1'b1, 1'b0}));
    set_req(1, 32'd2, 32'd3, 3'b100);
    bus.req_valid = 2'b10;
    #1;
    serve(1, 0, 2'b00, w, got);
    check("t3_lt", 64'(got[1]), 64'(0));
    set_req(1, 32'd2, 32'd3, 3'b000);
    bus.req_valid = 2'b10;
    #1;
    serve(1, 0, 2'b00, w, got);
    check("t3_add", 64'(got), 64'({32'd5, 1'b0, 1'b0}));

    // 4: response back-pressure with requester 0 waiting
    set_req(1, $urandom, $urandom, 3'b001);
    set_req(0, $urandom, $urandom, 3'b010);
    bus.req_valid = 2'b10;
    #1;
    serve(1, 5, 2'b01, w, got);
    serve(0, 0, 2'b00, w, got);
    check("t4_req0_wait", 64'(w), 64'(0));

    // 5: unused code returns zero
    set_req(0, 32'd1, 32'd1, 3'b111);
    bus.req_valid = 2'b01;
    #1;
    serve(0, 0, 2'b00, w, got);
    check("t5_code7", 64'(got), 64'({32'd0, 1'b0, 1'b1}));

    // 6: reset during EXEC drops the transaction
    set_req(0, 32'd9, 32'd9, 3'b000);
    bus.req_valid = 2'b01;
    #1;
    check("t6_grant", 64'(bus.req_ready), 64'(1));
    @(negedge clk); #1;
    check("t6_exec_busy", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    bus.req_valid = '0;
    @(negedge clk); #1;
    check("t6_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("t6_outputs", 64'({bus.rsp_result, bus.rsp_comp, bus.rsp_cero}), 64'(0));
    check("t6_alu", 64'({bus.alu_a, bus.alu_b, bus.alu_control}), 64'(0));
    check("t6_busy", 64'(bus.busy), 64'(0));
    rst = 1'b0;
    ptr_m = 0;
    @(negedge clk); #1;
    check("t6_no_rsp", 64'(bus.rsp_valid), 64'(0));
    set_req(0, $urandom, $urandom, 3'b000);
    set_req(1, $urandom, $urandom, 3'b001);
    bus.req_valid = 2'b11;
    #1;
    w = exp_winner(bus.req_valid);
    check("t6_ptr_reset", 64'(w), 64'(0));
    serve(w, 0, 2'b00, w, got);

    // random transactions
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < N; r++) begin
        ra = $urandom;
        set_req(r, ra, ($urandom_range(0, 3) == 0) ? ra : 32'($urandom),
                3'($urandom_range(0, 7)));
      end
      v = N'($urandom_range(1, (1 << N) - 1));
      bus.req_valid = v;
      #1;
      serve(exp_winner(v), $urandom_range(0, 2), N'($urandom_range(0, (1 << N) - 1)), w, got);
    end
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
